exe_muldiv: RTL and testbench

- Parametrised, multi-cycle execute-stage unit for the RV32M/RV64M multiply/divide group. It is the successor of the single-cycle ALU execute path.
- Sits beside the ALU in the EXE stage. Takes operands and the destination register from id_exe. Holds the pipeline via busy_o to the ctrl unit. Delivers the result and write-enable to exe_mem with a one-cycle done pulse.
- Iterative radix-2 datapath: one result bit per cycle. Special cases are resolved early.

---
 rtl/exe_muldiv_pkg.sv | 36 +++
 rtl/exe_muldiv_step.sv | 55 +++++
 rtl/exe_muldiv.sv | 237 +++++++++++++++++++++++
 tb/tb_exe_muldiv.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_muldiv_pkg.sv
// ---------------------------------------------------------------------------
// exe_muldiv_pkg
// Shared definitions for the EXE-stage multiply/divide unit. These are the
// same names the rest of the core uses in its defines header.
//   MdOpBus / MdOp_e       : width and encoding of the funct3 operation code
//   MdState_e              : IDLE / CALC / DONE state encoding
//   RstEnable              : level of the reset input that means "in reset"
//   WriteEnable/Disable    : register-file write-enable levels
// ---------------------------------------------------------------------------
package exe_muldiv_pkg;

    localparam int MdOpBus = 3;

    // funct3 encoding of the M-extension group
    typedef enum logic [MdOpBus-1:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } MdOp_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } MdState_e;

    localparam logic RstEnable    = 1'b1;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

endpackage

// File: rtl/exe_muldiv_step.sv
// ---------------------------------------------------------------------------
// muldiv_step
// One combinational radix-2 iteration shared by multiply and divide.
//   i_acc     : {hi, lo} accumulator (2*XLEN)
//   i_operand : multiplicand (mul) or divisor (div) magnitude
//   i_divMode : 0 = shift-add multiply, 1 = restoring shift-subtract divide
//   o_acc     : next accumulator
//   o_qBit    : quotient bit produced this step (0 in multiply mode)
// Multiply: lo holds the remaining multiplier bits, hi the partial product;
// the pair shifts right once per step.
// Divide: hi holds the partial remainder, lo the remaining dividend bits
// (shifting left); the quotient bit is reported separately and the caller
// ORs it into the vacated LSB of lo.
// ---------------------------------------------------------------------------
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [XLEN-1:0]   i_operand,
    input  logic              i_divMode,
    output logic [2*XLEN-1:0] o_acc,
    output logic              o_qBit
);

    logic [XLEN-1:0]   w_hi;
    logic [XLEN-1:0]   w_lo;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_mulAcc;
    logic [XLEN:0]     w_partial;
    logic [XLEN-1:0]   w_diff;
    logic              w_fits;
    logic [XLEN-1:0]   w_newRem;
    logic [2*XLEN-1:0] w_divAcc;

    assign w_hi = i_acc[2*XLEN-1:XLEN];
    assign w_lo = i_acc[XLEN-1:0];

    // Shift-add: the carry out of the addition becomes the new MSB after
    // the right shift, so the sum is kept one bit wider than XLEN.
    assign w_sum    = {1'b0, w_hi} + (w_lo[0] ? {1'b0, i_operand} : {(XLEN+1){1'b0}});
    assign w_mulAcc = {w_sum, w_lo[XLEN-1:1]};

    // Restoring subtract: the remainder is always below the divisor, so the
    // shifted partial is below twice the divisor and any successful
    // difference fits in XLEN bits (modulo arithmetic is exact here).
    assign w_partial = {w_hi, w_lo[XLEN-1]};
    assign w_fits    = (w_partial >= {1'b0, i_operand});
    assign w_diff    = w_partial[XLEN-1:0] - i_operand;
    assign w_newRem  = w_fits ? w_diff : w_partial[XLEN-1:0];
    assign w_divAcc  = {w_newRem, w_lo[XLEN-2:0], 1'b0};

    assign o_acc  = i_divMode ? w_divAcc : w_mulAcc;
    assign o_qBit = i_divMode & w_fits;

endmodule

// File: rtl/exe_muldiv.sv
// ---------------------------------------------------------------------------
// exe_muldiv
// Multi-cycle RV32M/RV64M multiply/divide unit in the EXE stage.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   start_i, flush_i        : issue request (IDLE only) / abort from ctrl
//   op_i                    : funct3 operation code (MdOp_e)
//   op1_i, op2_i            : rs1 / rs2 values
//   reg_waddr_i             : destination register of the issuing instruction
//   busy_o                  : stall request to ctrl
//   done_o, reg_we_o        : one-cycle result-valid / write-enable pulse
//   reg_waddr_o, reg_wdata_o: latched destination and held result
// Build option:
//   EXE_MULDIV_FAST_MUL_EN  : multiplies use one registered multiplier and
//                             finish one cycle after start; divides unchanged.
// ---------------------------------------------------------------------------
module exe_muldiv
    import exe_muldiv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               flush_i,
    input  logic [MdOpBus-1:0] op_i,
    input  logic [XLEN-1:0]    op1_i,
    input  logic [XLEN-1:0]    op2_i,
    input  logic [REG_AW-1:0]  reg_waddr_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               reg_we_o,
    output logic [REG_AW-1:0]  reg_waddr_o,
    output logic [XLEN-1:0]    reg_wdata_o
);

    localparam int                CntW    = $clog2(XLEN);
    localparam logic [CntW-1:0]   CntInit = CntW'(XLEN - 1);
    localparam logic [XLEN-1:0]   MinNeg  = {1'b1, {(XLEN-1){1'b0}}};

    MdState_e          r_state;
    MdState_e          w_nextState;
    MdOp_e             r_op;
    logic [CntW-1:0]   r_count;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_operand;
    logic              r_negRes;
    logic [REG_AW-1:0] r_waddr;
    logic [XLEN-1:0]   r_wdata;

    logic              w_busy;
    logic              w_done;
    logic              w_accept;

    logic              w_isDiv;
    logic              w_isRem;
    logic              w_op1Signed;
    logic              w_op2Signed;
    logic              w_op1Neg;
    logic              w_op2Neg;
    logic [XLEN-1:0]   w_mag1;
    logic [XLEN-1:0]   w_mag2;
    logic              w_negRes;
    logic              w_divZero;
    logic              w_divOvf;
    logic              w_mulZero;
    logic              w_special;
    logic              w_early;
    logic [XLEN-1:0]   w_specialRes;
    logic [XLEN-1:0]   w_earlyRes;

    logic [2*XLEN-1:0] w_stepAcc;
    logic              w_qBit;
    logic [2*XLEN-1:0] w_finalAcc;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_calcRes;

    // Decode of the incoming request: which operands are signed, their
    // magnitudes, and which sign the final result must carry. Remainders
    // follow the dividend; products and quotients follow the XOR of signs.
    assign w_isDiv     = op_i[2];
    assign w_isRem     = (op_i == MD_REM) | (op_i == MD_REMU);
    assign w_op1Signed = (op_i != MD_MULHU) & (op_i != MD_DIVU) & (op_i != MD_REMU);
    assign w_op2Signed = (op_i == MD_MUL) | (op_i == MD_MULH) |
                         (op_i == MD_DIV) | (op_i == MD_REM);
    assign w_op1Neg    = w_op1Signed & op1_i[XLEN-1];
    assign w_op2Neg    = w_op2Signed & op2_i[XLEN-1];
    assign w_mag1      = w_op1Neg ? (-op1_i) : op1_i;
    assign w_mag2      = w_op2Neg ? (-op2_i) : op2_i;
    assign w_negRes    = w_isRem ? w_op1Neg : (w_op1Neg ^ w_op2Neg);

    // Cases whose answer is known without iterating; they skip CALC.
    assign w_divZero = w_isDiv & (op2_i == '0);
    assign w_divOvf  = ((op_i == MD_DIV) | (op_i == MD_REM)) &
                       (op1_i == MinNeg) & (op2_i == '1);
    assign w_mulZero = ~w_isDiv & ((op1_i == '0) | (op2_i == '0));
    assign w_special = w_divZero | w_divOvf | w_mulZero;

    // Result for the early-out cases; divide-by-zero takes priority since
    // a zero divisor can never also be the overflow pattern.
    always_comb begin
        w_specialRes = '0;
        if (w_divZero) begin
            w_specialRes = w_isRem ? op1_i : '1;
        end else if (w_divOvf) begin
            w_specialRes = w_isRem ? '0 : op1_i;
        end
    end

`ifdef EXE_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fastMag;
    logic [2*XLEN-1:0] w_fastProd;

    // A single multiplier on the magnitudes; its sign-corrected product is
    // captured into the result register on the start edge.
    assign w_fastMag  = {{XLEN{1'b0}}, w_mag1} * {{XLEN{1'b0}}, w_mag2};
    assign w_fastProd = w_negRes ? (-w_fastMag) : w_fastMag;
    assign w_early    = w_special | ~w_isDiv;
    assign w_earlyRes = w_special ? w_specialRes :
                        (w_isDiv ? '0 :
                         ((op_i == MD_MUL) ? w_fastProd[XLEN-1:0] : w_fastProd[2*XLEN-1:XLEN]));
`else
    assign w_early    = w_special;
    assign w_earlyRes = w_specialRes;
`endif

    muldiv_step #(
        .XLEN(XLEN)
    ) u_step (
        .i_acc    (r_acc),
        .i_operand(r_operand),
        .i_divMode(r_op[2]),
        .o_acc    (w_stepAcc),
        .o_qBit   (w_qBit)
    );

    assign w_finalAcc = w_stepAcc | {{(2*XLEN-1){1'b0}}, w_qBit};

    // Sign correction of the accumulator after the last iteration; the
    // product is negated at full width so MULH* sees the borrow.
    always_comb begin
        w_prod    = r_negRes ? (-w_finalAcc) : w_finalAcc;
        w_quot    = r_negRes ? (-w_finalAcc[XLEN-1:0]) : w_finalAcc[XLEN-1:0];
        w_rem     = r_negRes ? (-w_finalAcc[2*XLEN-1:XLEN]) : w_finalAcc[2*XLEN-1:XLEN];
        w_calcRes = '0;
        case (r_op)
            MD_MUL:                        w_calcRes = w_prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  w_calcRes = w_prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               w_calcRes = w_quot;
            MD_REM, MD_REMU:               w_calcRes = w_rem;
            default:                       w_calcRes = '0;
        endcase
    end

    // Next-state and handshake outputs. busy_o in IDLE is combinational so
    // the issuing instruction stalls in its own cycle; done is suppressed
    // combinationally by a flush arriving in the DONE cycle.
    always_comb begin
        w_nextState = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i && !flush_i) begin
                    w_busy      = 1'b1;
                    w_accept    = 1'b1;
                    w_nextState = w_early ? DONE : CALC;
                end
            end
            CALC: begin
                w_busy = 1'b1;
                if (flush_i) begin
                    w_nextState = IDLE;
                end else if (r_count == '0) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_done      = ~flush_i;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i == RstEnable) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Datapath registers: request capture on accept, one iteration per CALC
    // cycle, and the result loaded on the way into DONE. A flushed final
    // iteration leaves the previous result untouched.
    always_ff @(posedge clk_i) begin
        if (rst_i == RstEnable) begin
            r_op      <= MD_MUL;
            r_count   <= '0;
            r_acc     <= '0;
            r_operand <= '0;
            r_negRes  <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
        end else if (w_accept) begin
            r_op     <= MdOp_e'(op_i);
            r_waddr  <= reg_waddr_i;
            r_negRes <= w_negRes;
            r_count  <= CntInit;
            if (w_early) begin
                r_wdata <= w_earlyRes;
            end else begin
                r_acc     <= {{XLEN{1'b0}}, (w_isDiv ? w_mag1 : w_mag2)};
                r_operand <= w_isDiv ? w_mag2 : w_mag1;
            end
        end else if ((r_state == CALC) && !flush_i) begin
            r_acc   <= w_finalAcc;
            r_count <= r_count - CntW'(1);
            if (r_count == '0) begin
                r_wdata <= w_calcRes;
            end
        end
    end

    assign busy_o      = w_busy;
    assign done_o      = w_done;
    assign reg_we_o    = w_done ? WriteEnable : WriteDisable;
    assign reg_waddr_o = r_waddr;
    assign reg_wdata_o = r_wdata;

endmodule

// File: tb/tb_exe_muldiv.sv
// ---------------------------------------------------------------------------
// tb_exe_muldiv
// Directed, table-driven bench for exe_muldiv (XLEN=32). Expected results
// and latencies are hand-computed constants in the vector table; flush,
// reset and back-to-back behaviour are exercised by short hand sequences.
// ---------------------------------------------------------------------------
module tb_exe_muldiv;

   localparam int XLEN = 32;
`ifdef EXE_MULDIV_FAST_MUL_EN
   localparam int MulLat = 1;
`else
   localparam int MulLat = 33;
`endif
   localparam int DivLat = 33;

   logic        clk;
   logic        rst;
   logic        start;
   logic        flush;
   logic [2:0]  opIn;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [4:0]  waddrIn;
   logic        busy;
   logic        done;
   logic        regWe;
   logic [4:0]  waddrOut;
   logic [31:0] wdata;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expRes;
      int          expLat;
   } vec_t;

   vec_t vecs [20];

   exe_muldiv #(
      .XLEN(XLEN),
      .REG_AW(5)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .flush_i    (flush),
      .op_i       (opIn),
      .op1_i      (op1),
      .op2_i      (op2),
      .reg_waddr_i(waddrIn),
      .busy_o     (busy),
      .done_o     (done),
      .reg_we_o   (regWe),
      .reg_waddr_o(waddrOut),
      .reg_wdata_o(wdata)
   );

   // Free-running clock, 10 time units per cycle
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compare one value against its expected constant and keep the tallies
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
      end
   endtask

   // Fill one row of the vector table
   task automatic setVec(input int idx, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expRes, input int expLat);
      vecs[idx].op     = op;
      vecs[idx].a      = a;
      vecs[idx].b      = b;
      vecs[idx].expRes = expRes;
      vecs[idx].expLat = expLat;
   endtask

   // Issue one operation in an IDLE cycle (cycle N), then follow it until
   // done_o. Latency is counted in cycles after N; busy cycles include N.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] wa, output int lat, output int busyCycles,
                                output logic [31:0] res, output logic [4:0] waOut, output logic weAtDone);
      @(negedge clk);
      start   = 1'b1;
      opIn    = op;
      op1     = a;
      op2     = b;
      waddrIn = wa;
      #1;
      busyCycles = busy ? 1 : 0;
      @(negedge clk);
      start = 1'b0;
      op1   = 32'hDEAD_BEEF;
      op2   = 32'h0BAD_F00D;
      lat   = 1;
      #1;
      while (!done && lat < 200) begin
         if (busy) busyCycles++;
         @(negedge clk);
         lat++;
         #1;
      end
      if (busy) busyCycles++;
      res      = wdata;
      waOut    = waddrOut;
      weAtDone = regWe;
   endtask

   initial begin
      int          lat;
      int          busyCycles;
      logic [31:0] res;
      logic [4:0]  waOut;
      logic        we;
      int          sawDone;

      rst     = 1'b1;
      start   = 1'b0;
      flush   = 1'b0;
      opIn    = 3'd0;
      op1     = '0;
      op2     = '0;
      waddrIn = '0;

      // Vector table: op, op1, op2, expected result, expected latency
      setVec(0,  3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MulLat);
      setVec(1,  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MulLat);
      setVec(2,  3'd2, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, MulLat);
      setVec(3,  3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MulLat);
      setVec(4,  3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, DivLat);
      setVec(5,  3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, DivLat);
      setVec(6,  3'd5, 32'd100,      32'd7,        32'd14,        DivLat);
      setVec(7,  3'd7, 32'd100,      32'd7,        32'd2,         DivLat);
      setVec(8,  3'd5, 32'd10,       32'd0,        32'hFFFF_FFFF, 1);
      setVec(9,  3'd6, 32'd10,       32'd0,        32'd10,        1);
      setVec(10, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      setVec(11, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1);
      setVec(12, 3'd0, 32'd0,        32'h0001_2345, 32'd0,        1);
      setVec(13, 3'd1, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, MulLat);
      setVec(14, 3'd4, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, DivLat);
      setVec(15, 3'd6, 32'd7,        32'hFFFF_FFFE, 32'd1,        DivLat);
      setVec(16, 3'd5, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, DivLat);
      setVec(17, 3'd3, 32'h1234_5678, 32'h0000_0010, 32'd1,        MulLat);
      setVec(18, 3'd0, 32'h0001_0000, 32'h0001_0000, 32'd0,        MulLat);
      setVec(19, 3'd7, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 1);

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset_busy",  {63'd0, busy},  64'd0);
      checkOutput("reset_done",  {63'd0, done},  64'd0);
      checkOutput("reset_we",    {63'd0, regWe}, 64'd0);
      checkOutput("reset_waddr", {59'd0, waddrOut}, 64'd0);
      checkOutput("reset_wdata", {32'd0, wdata}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Table-driven vectors
      for (int i = 0; i < 20; i++) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), lat, busyCycles, res, waOut, we);
         checkOutput($sformatf("vec%0d_result", i),  {32'd0, res},   {32'd0, vecs[i].expRes});
         checkOutput($sformatf("vec%0d_latency", i), 64'(lat),        64'(vecs[i].expLat));
         checkOutput($sformatf("vec%0d_busy", i),    64'(busyCycles), 64'(vecs[i].expLat));
         checkOutput($sformatf("vec%0d_waddr", i),   {59'd0, waOut},  64'(i + 1));
         checkOutput($sformatf("vec%0d_we", i),      {63'd0, we},     64'd1);
      end

      // Flush in the tenth CALC cycle: no completion, idle next cycle
      @(negedge clk);
      start = 1'b1; opIn = 3'd5; op1 = 32'd100; op2 = 32'd7; waddrIn = 5'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      #1;
      checkOutput("flushCalc_busyDuring", {63'd0, busy}, 64'd1);
      @(negedge clk);
      flush = 1'b0;
      #1;
      checkOutput("flushCalc_busyAfter", {63'd0, busy}, 64'd0);
      sawDone = 0;
      for (int c = 0; c < 40; c++) begin
         if (done || regWe) sawDone++;
         @(negedge clk);
         #1;
      end
      checkOutput("flushCalc_noDone", 64'(sawDone), 64'd0);
      applyStimulus(3'd4, 32'd50, 32'd5, 5'd4, lat, busyCycles, res, waOut, we);
      checkOutput("afterFlushCalc_result",  {32'd0, res}, 64'd10);
      checkOutput("afterFlushCalc_latency", 64'(lat),     64'(DivLat));

      // Flush arriving in the DONE cycle suppresses done and write-enable
      @(negedge clk);
      start = 1'b1; opIn = 3'd5; op1 = 32'd100; op2 = 32'd7; waddrIn = 5'd8;
      @(negedge clk);
      start = 1'b0;
      repeat (31) @(negedge clk);
      #1;
      checkOutput("flushDone_notYet", {63'd0, done}, 64'd0);
      @(negedge clk);
      flush = 1'b1;
      #1;
      checkOutput("flushDone_done", {63'd0, done},  64'd0);
      checkOutput("flushDone_we",   {63'd0, regWe}, 64'd0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      checkOutput("flushDone_idleBusy", {63'd0, busy}, 64'd0);
      checkOutput("flushDone_idleDone", {63'd0, done}, 64'd0);
      applyStimulus(3'd7, 32'd100, 32'd7, 5'd9, lat, busyCycles, res, waOut, we);
      checkOutput("afterFlushDone_result", {32'd0, res}, 64'd2);

      // Reset in the middle of CALC clears every output
      @(negedge clk);
      start = 1'b1; opIn = 3'd0; op1 = 32'd3; op2 = 32'd5; waddrIn = 5'd12;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("midReset_busy",  {63'd0, busy},     64'd0);
      checkOutput("midReset_done",  {63'd0, done},     64'd0);
      checkOutput("midReset_we",    {63'd0, regWe},    64'd0);
      checkOutput("midReset_waddr", {59'd0, waddrOut}, 64'd0);
      checkOutput("midReset_wdata", {32'd0, wdata},    64'd0);

      // Back-to-back divides with start held: the second is taken only in
      // the IDLE cycle after DONE, and each reports its own destination
      @(negedge clk);
      start = 1'b1; opIn = 3'd5; op1 = 32'd100; op2 = 32'd7; waddrIn = 5'd5;
      @(negedge clk);
      op1 = 32'd50; op2 = 32'd5; waddrIn = 5'd6;
      lat = 1;
      #1;
      while (!done && lat < 200) begin
         @(negedge clk);
         lat++;
         #1;
      end
      checkOutput("b2b_first_latency", 64'(lat),          64'(DivLat));
      checkOutput("b2b_first_result",  {32'd0, wdata},    64'd14);
      checkOutput("b2b_first_waddr",   {59'd0, waddrOut}, 64'd5);
      @(negedge clk);
      #1;
      checkOutput("b2b_accept_busy", {63'd0, busy}, 64'd1);
      checkOutput("b2b_accept_done", {63'd0, done}, 64'd0);
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      #1;
      while (!done && lat < 200) begin
         @(negedge clk);
         lat++;
         #1;
      end
      checkOutput("b2b_second_latency", 64'(lat),          64'(DivLat));
      checkOutput("b2b_second_result",  {32'd0, wdata},    64'd10);
      checkOutput("b2b_second_waddr",   {59'd0, waddrOut}, 64'd6);
      checkOutput("b2b_second_we",      {63'd0, regWe},    64'd1);

      // Result is held after the done pulse
      @(negedge clk);
      #1;
      checkOutput("hold_done",  {63'd0, done},  64'd0);
      checkOutput("hold_wdata", {32'd0, wdata}, 64'd10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
